// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: one-hot ALU, data SRAM request and an iterative DIV/DIVU unit.
// Defining EX_FWD_EN adds the ex_to_id_fwd bypass port toward the decode stage.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 141,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
`ifdef EX_FWD_EN
  ,
  output logic [37:0]             ex_to_id_fwd
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  logic [ID_TO_EX_WD-1:0] id_ex;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] ex_result;

  logic        load;
  logic        is_div;
  logic        div_signed;
  logic        div_start;
  logic [1:0]  div_state;
  logic [5:0]  div_cnt;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] div_d;
  logic        neg_q;
  logic        neg_r;
  logic        div_done;
  logic [63:0] div_next;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        unused_bits;

  // One restoring shift-subtract step; returns {remainder, quotient}.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {r, q[31]};
    diff = sh - {1'b0, d};
    if (diff[32]) begin
      div_step = {sh[31:0], q[30:0], 1'b0};
    end else begin
      div_step = {diff[31:0], q[30:0], 1'b1};
    end
  endfunction

  function automatic logic [31:0] abs_val(input logic neg, input logic [31:0] v);
    if (neg) begin
      abs_val = 32'd0 - v;
    end else begin
      abs_val = v;
    end
  endfunction

  // A stalled stage whose successor is running must emit a bubble.
  assign load = ~stall[2] | ~stall[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex <= {ID_TO_EX_WD{1'b0}};
    end else if (stall[2] && !stall[3]) begin
      id_ex <= {ID_TO_EX_WD{1'b0}};
    end else if (!stall[2]) begin
      id_ex <= id_to_ex_bus;
    end else begin
      id_ex <= id_ex;
    end
  end

  assign {pc, inst, alu_op, sel_src1, sel_src2, data_ram_en, data_ram_wen,
          rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_ex;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'h0000, inst[15:0]};

  always_comb begin
    src1 = ({32{sel_src1[0]}} & rdata1)
         | ({32{sel_src1[1]}} & pc)
         | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
    src2 = ({32{sel_src2[0]}} & rdata2)
         | ({32{sel_src2[1]}} & imm_sext)
         | ({32{sel_src2[2]}} & 32'd8)
         | ({32{sel_src2[3]}} & imm_zext);
  end

  // One-hot op select: with no bit set every term masks to zero.
  always_comb begin
    ex_result = ({32{alu_op[11]}} & (src1 + src2))
              | ({32{alu_op[10]}} & (src1 - src2))
              | ({32{alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
              | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
              | ({32{alu_op[7]}}  & (src1 & src2))
              | ({32{alu_op[6]}}  & ~(src1 | src2))
              | ({32{alu_op[5]}}  & (src1 | src2))
              | ({32{alu_op[4]}}  & (src1 ^ src2))
              | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
              | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
              | ({32{alu_op[1]}}  & 32'($signed(src2) >>> src1[4:0]))
              | ({32{alu_op[0]}}  & {src2[15:0], 16'h0000});
  end

  assign data_sram_en    = data_ram_en;
  assign data_sram_wen   = data_ram_wen;
  assign data_sram_addr  = rdata1 + imm_sext;
  assign data_sram_wdata = rdata2;

  assign is_div     = (inst[31:26] == 6'h00) && ((inst[5:0] == 6'h1A) || (inst[5:0] == 6'h1B));
  assign div_signed = (inst[5:0] == 6'h1A);
  assign div_start  = (div_state == S_IDLE) && is_div && !div_done;
  assign stallreq_for_ex = div_start || (div_state == S_RUN);
  assign div_next   = div_step(div_r, div_q, div_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state <= S_IDLE;
      div_cnt   <= 6'd0;
      div_q     <= 32'd0;
      div_r     <= 32'd0;
      div_d     <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (div_state)
        S_IDLE: begin
          if (div_start) begin
            div_q     <= abs_val(div_signed & rdata1[31], rdata1);
            div_d     <= abs_val(div_signed & rdata2[31], rdata2);
            div_r     <= 32'd0;
            div_cnt   <= 6'd0;
            neg_q     <= div_signed & (rdata1[31] ^ rdata2[31]);
            neg_r     <= div_signed & rdata1[31];
            div_state <= S_RUN;
          end else begin
            div_state <= S_IDLE;
          end
        end
        S_RUN: begin
          div_r   <= div_next[63:32];
          div_q   <= div_next[31:0];
          div_cnt <= div_cnt + 6'd1;
          if (div_cnt == LAST_STEP) begin
            div_state <= S_DONE;
          end else begin
            div_state <= S_RUN;
          end
        end
        S_DONE: begin
          div_state <= S_IDLE;
        end
        default: begin
          div_state <= S_IDLE;
        end
      endcase
    end
  end

  // The done flag keeps a held div from restarting; any register load clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_done <= 1'b0;
    end else if (load) begin
      div_done <= 1'b0;
    end else if (div_state == S_DONE) begin
      div_done <= 1'b1;
    end else begin
      div_done <= div_done;
    end
  end

  always_comb begin
    hilo_we = 1'b0;
    hi      = 32'd0;
    lo      = 32'd0;
    if (div_state == S_DONE) begin
      hilo_we = 1'b1;
      if (div_d == 32'd0) begin
        lo = 32'hFFFF_FFFF;
        hi = rdata1;
      end else begin
        lo = abs_val(neg_q, div_q);
        hi = abs_val(neg_r, div_r);
      end
    end else begin
      hilo_we = 1'b0;
    end
  end

  assign ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
                          ex_result, hilo_we, hi, lo};

`ifdef EX_FWD_EN
  assign ex_to_id_fwd = stallreq_for_ex ? 38'd0 : {rf_we, rf_waddr, ex_result};
`endif

  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expected outputs, a monitor pops them on exit.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_ext;
  logic         stallreq_for_ex;
  logic [158:0] id_bus;
  logic [140:0] ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
`ifdef EX_FWD_EN
  logic [37:0]  ex_to_id_fwd;
`endif

  typedef struct packed {
    logic [140:0] mem;
    logic [68:0]  sram;
    logic [7:0]   slen;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .stallreq_for_ex (stallreq_for_ex),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
`ifdef EX_FWD_EN
    ,
    .ex_to_id_fwd    (ex_to_id_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline controller: a busy EX stage freezes itself and upstream, bubbling MEM.
  always_comb stall = stallreq_for_ex ? 6'b001111 : stall_ext;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_exit();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!stallreq_for_ex) begin
        seen = 1'b1;
        break;
      end
    end
    chk("exit_timeout", {159'd0, seen}, 160'd1);
  endtask

  task automatic run(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
                     input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
                     input logic [3:0] wen, input logic rfw, input logic [4:0] wa,
                     input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] res,
                     input logic hw, input logic [31:0] hi, input logic [31:0] lo,
                     input logic [31:0] addr, input logic [7:0] slen);
    exp_t e;
    @(negedge clk);
    id_bus = {pc, inst, op, s1, s2, ram_en, wen, rfw, wa, 1'b0, rd1, rd2};
    e.mem  = {pc, ram_en, wen, 1'b0, rfw, wa, res, hw, hi, lo};
    e.sram = {ram_en, wen, addr, rd2};
    e.slen = slen;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    id_bus = 159'd0;
    wait_exit();
  endtask

  // Monitor: an instruction leaves EX on a cycle with no stall request and a nonzero pc.
  initial begin
    exp_t e;
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (stallreq_for_ex) begin
        stall_cnt++;
      end else begin
        if (ex_to_mem_bus[140:109] != 32'd0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", ex_to_mem_bus);
          end else begin
            e = exp_q.pop_front();
            chk("mem_bus", {19'd0, ex_to_mem_bus}, {19'd0, e.mem});
            chk("sram_req", {91'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                {91'd0, e.sram});
            chk("stall_len", 160'(stall_cnt), {152'd0, e.slen});
          end
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    stall_ext = 6'b000000;
    id_bus    = 159'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {19'd0, ex_to_mem_bus}, 160'd0);
    chk("reset_stallreq", {159'd0, stallreq_for_ex}, 160'd0);
    chk("reset_sram_en", {159'd0, data_sram_en}, 160'd0);
    rst = 1'b0;

    // ori, lui, subu, slt, sltu, sra, jal-style pc+8
    run(32'hBFC0_0000, 32'h3422_0034, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2,
        32'h0000_1200, 32'hDEAD_0000, 32'h0000_1234, 1'b0, 32'd0, 32'd0, 32'h0000_1234, 8'd0);
    run(32'hBFC0_0004, 32'h3C03_ABCD, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd3,
        32'd0, 32'd0, 32'hABCD_0000, 1'b0, 32'd0, 32'd0, 32'hFFFF_ABCD, 8'd0);
    run(32'hBFC0_0008, 32'h0085_3023, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd6,
        32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd0, 32'd0, 32'h0000_3028, 8'd0);
    run(32'hBFC0_000C, 32'h0022_182A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
        32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0, 32'h0000_1829, 8'd0);
    run(32'hBFC0_0010, 32'h0022_182B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
        32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 32'd0, 32'h0000_182A, 8'd0);
    run(32'hBFC0_0014, 32'h0002_1903, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
        32'd0, 32'h8000_0010, 32'hF800_0001, 1'b0, 32'd0, 32'd0, 32'h0000_1903, 8'd0);
    run(32'hBFC0_0100, 32'h0C00_0040, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31,
        32'd0, 32'd0, 32'hBFC0_0108, 1'b0, 32'd0, 32'd0, 32'h0000_0040, 8'd0);

    // Divides: DIVU 100/7, DIV -7/2, DIV 5/0, DIV 0x80000000/-1, DIVU 0xFFFFFFFF/16
    run(32'hBFC0_0200, 32'h0022_001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
        32'd100, 32'd7, 32'd0, 1'b1, 32'd2, 32'd14, 32'h0000_007F, 8'd33);
    run(32'hBFC0_0204, 32'h0022_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
        32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0013, 8'd33);
    run(32'hBFC0_0208, 32'h0022_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
        32'd5, 32'd0, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 32'h0000_001F, 8'd33);
    run(32'hBFC0_020C, 32'h0022_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
        32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 32'h8000_0000, 32'h8000_001A, 8'd33);
    run(32'hBFC0_0210, 32'h0022_001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
        32'hFFFF_FFFF, 32'h0000_0010, 32'd0, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF,
        32'h0000_001A, 8'd33);

    // Reset in the tenth RUN cycle of a divide
    @(negedge clk);
    id_bus = {32'hBFC0_0300, 32'h0022_001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0,
              1'b0, 32'd100, 32'd7};
    @(posedge clk);
    #1;
    id_bus = 159'd0;
    repeat (11) @(negedge clk);
    chk("div_running", {159'd0, stallreq_for_ex}, 160'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_stallreq", {159'd0, stallreq_for_ex}, 160'd0);
    chk("midreset_bus", {19'd0, ex_to_mem_bus}, 160'd0);
    rst = 1'b0;
    run(32'hBFC0_0304, 32'h3422_0034, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2,
        32'h0000_1200, 32'h0000_0055, 32'h0000_1234, 1'b0, 32'd0, 32'd0, 32'h0000_1234, 8'd0);

    // sw request, then a forced bubble
    run(32'hBFC0_0400, 32'hAC22_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
        32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0FFC, 1'b0, 32'd0, 32'd0, 32'h0000_0FFC, 8'd0);
    id_bus = {32'hBFC0_0404, 32'hAC22_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
              1'b0, 32'h0000_1000, 32'hCAFE_F00D};
    stall_ext = 6'b000111;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_sram_en", {159'd0, data_sram_en}, 160'd0);
    chk("bubble_bus", {19'd0, ex_to_mem_bus}, 160'd0);
    stall_ext = 6'b000000;
    id_bus    = 159'd0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 160'(exp_q.size()), 160'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the decode stage.
- Registers the decode-to-execute bus and evaluates the one-hot ALU operation.
- Issues the data SRAM request for loads and stores, and forwards results to the memory stage.
- Contains an iterative 32-cycle divider for DIV/DIVU; it holds the pipeline through stallreq while busy.

Parameters:
- ID_TO_EX_WD, 159: width of the incoming bus.
- EX_TO_MEM_WD, 141: width of the outgoing bus.
- DIV_CYCLES, 32: number of divider iterations. Fixed at 32; any other value is unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 2 = this stage, bit 3 = memory stage; 1 = Stop
- stallreq_for_ex  out  1  stage requests stall (divider busy)
- id_to_ex_bus  in  159  packed MSB→LSB as:
  - pc[31:0], inst[31:0], alu_op[11:0] {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  - sel_src1[2:0] {sa,pc,rs}, sel_src2[3:0] {immzext,8,immsext,rt}
  - data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1[31:0], rdata2[31:0]
- ex_to_mem_bus  out  141  packed MSB→LSB as:
  - pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], hilo_we, hi[31:0], lo[31:0]
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  data SRAM address
- data_sram_wdata  out  32  data SRAM write data

Behaviour:
- Input register:
  - Cleared to 0 on rst.
  - stall[2]=Stop and stall[3]=NoStop: loads 0 (bubble).
  - stall[2]=NoStop: loads id_to_ex_bus.
  - Otherwise holds.
- A zero register is inert: every enable is 0 and pc is 0.
- Operand selects are one-hot:
  - src1 = rdata1, pc, or {27'b0, inst[10:6]}.
  - src2 = rdata2, sign-extended inst[15:0], 32'd8, or zero-extended inst[15:0].
- ALU:
  - add/sub: 32-bit wrap, no overflow trap.
  - slt: signed compare; sltu: unsigned compare.
  - sll/srl/sra: shift src2 by src1[4:0].
  - lui: src2 << 16.
  - No op bit set: result 0.
- Memory request, combinational from the register:
  - data_sram_en = data_ram_en; data_sram_wen = data_ram_wen.
  - data_sram_addr = rdata1 + sign-extended inst[15:0].
  - data_sram_wdata = rdata2.
- Outputs are 0 during reset and bubbles.
- Divider select: inst[31:26]=0 and inst[5:0]=6'h1A (DIV, signed) or 6'h1B (DIVU).
- Divider FSM states IDLE, RUN, DONE; reset state is IDLE.
  - IDLE with div decoded: latch |rs| and |rt| (raw values for DIVU) and the sign bits; clear the counter; go to RUN.
  - RUN: one restoring shift-subtract step per cycle. After the 32nd step go to DONE.
  - DONE: apply signs. Quotient is negated when the operand signs differ; remainder takes the dividend's sign. Present lo=quotient, hi=remainder, hilo_we=1, then go to IDLE.
- stallreq_for_ex:
  - Combinational: 1 in IDLE-with-div and in RUN, 0 in DONE.
  - A div instruction therefore stalls for 33 cycles and exits EX in the DONE cycle.
- Divide by zero completes normally: lo=32'hFFFFFFFF, hi=dividend; signs are not applied.
- 32'h80000000 / -1 (DIV): lo=32'h80000000, hi=0.
- hilo_we=0 for all non-div instructions; hi/lo are then 0.
- Reset mid-divide: FSM returns to IDLE, counter clears, stallreq drops in the next cycle.
- A div instruction is never re-triggered from DONE. IDLE only starts a new divide after the register has loaded a new instruction; a one-bit "done" flag clears on the next load.
- All state is single-clock; there are no multicycle paths.

Optional Feature:
- Macro EX_FWD_EN.
- Defined: adds output ex_to_id_fwd[37:0] = {rf_we, rf_waddr[4:0], ex_result[31:0]} for decode-stage bypass. Fields are zeroed for bubbles and while stallreq_for_ex=1.
- Undefined: the port does not exist and no bypass logic is built.

Test Plan:
- ori: rdata1=32'h0000_1200, imm=16'h0034, alu_op=or, src1=rs, src2=immzext -> ex_result=32'h0000_1234, rf_we=1 one cycle after load.
- lui: imm=16'hABCD -> ex_result=32'hABCD_0000.
- DIVU 100/7 -> stallreq high exactly 33 cycles; DONE cycle gives lo=14, hi=2, hilo_we=1.
- DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV 5/0 -> lo=32'hFFFF_FFFF, hi=5.
- Assert rst during RUN cycle 10 -> next cycle stallreq=0 and register=0; a following ori executes normally.
- sw with rdata1=32'h1000, imm=16'hFFFC, wen=4'hF -> addr=32'h0FFC, wdata=rdata2. Then stall=6'b000111 -> bubble, data_sram_en=0.
